dma_addr_gen_mc: RTL and testbench
==================================

Name: dma_addr_gen_mc

Overview:
Multi-channel, parametrised successor to the team's single-channel 8-bit DMA address generator. Each of NCH channels holds its own address register, word-count register, address counter, word counter, control register and done state. All channels share one instruction/data interface and one count-step interface. Adds an address-direction bit, an auto-reinitialise mode and a registered address output with handshake.

Parameters:
W, 16, address and word-count width (also din/dout width)
NCH, 4, number of channels (power of 2, >=2)
CHW, $clog2(NCH), channel index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
instr_vld  in  1  execute instr on ch_sel this cycle
instr  in  3  instruction code
ch_sel  in  CHW  channel targeted by instr
din  in  W  instruction data
dout  out  W  readback data
dout_vld  out  1  dout valid (1-cycle pulse)
cnt_en  in  1  request one transfer step on cnt_ch
cnt_ch  in  CHW  channel to step
cnt_ack  out  1  step accepted (1-cycle pulse)
addr  out  W  address issued for the accepted step
aco  out  1  address carry/borrow on accepted step
wco  out  1  word-count carry/borrow on accepted step
done  out  NCH  per-channel terminal-count level
done_pls  out  1  pulse on any channel terminal count (incl. auto-reinit)

Behaviour:
- Per-channel state: AR[W], WCR[W], AC[W], WC[W], CR[3:0], EN.
- CR[1:0] mode: 00 WC counts down, terminal when WC reaches 0; 01 WC counts up from 0, terminal when WC==WCR; 10 address compare, terminal when AC==WCR; 11 free-run, never terminal. CR[2]: 0 AC increments, 1 AC decrements. CR[3]: auto-reinit.
- "Reload" means AC<=AR; WC<=WCR in mode 00, else WC<=0.
- Instructions, executed at the clock edge with instr_vld=1, on channel ch_sel:
  - 0 WR_CR: CR<=din[3:0]; EN<=0; done<=0.
  - 1 RD_CR: dout<={0,CR}.
  - 2 RD_WC: dout<=WC.
  - 3 RD_AC: dout<=AC.
  - 4 REINIT: reload; done<=0.
  - 5 LD_AR: AR<=din; AC<=din.
  - 6 LD_WCR: WCR<=din; WC<=din in mode 00, else WC<=0.
  - 7 ENABLE: EN<=din[0]; done<=0.
- dout_vld pulses 1 cycle after RD_* only. dout holds its last value otherwise.
- Step accepted when cnt_en=1, EN[cnt_ch]=1, done[cnt_ch]=0, and there is no same-cycle instruction on that channel.
  - A same-cycle instruction on the same channel wins: the step is dropped and cnt_ack=0.
  - Different channels: both the instruction and the step execute.
- Accepted step, with 1-cycle latency: next cycle cnt_ack=1, addr=AC value before the step, and AC<=AC±1 (wraps modulo 2^W).
  - aco=1 if AC wrapped (all-ones->0 when incrementing, 0->all-ones when decrementing).
  - Mode 00: WC<=WC-1; wco=1 when WC goes 1->0 or wraps 0->all-ones. WCR=0 therefore gives 2^W transfers.
  - Modes 01/10/11: WC<=WC+1; wco=1 on all-ones->0.
- Terminal check uses the post-step values.
  - If terminal and CR[3]=0: done<=1; EN stays 1, but further steps are refused until REINIT/WR_CR/ENABLE.
  - If terminal and CR[3]=1: reload instead of the step update, done stays 0.
  - Both cases pulse done_pls with cnt_ack.
- Reset (async) clears everything:
  - All AR, WCR, AC, WC, CR, EN <= 0.
  - done=0, dout=0, dout_vld=0, cnt_ack=0, addr=0, aco=0, wco=0, done_pls=0.
  - Reset mid-step discards the step and no ack appears.
- Outputs are registered, with no combinational path from inputs.

Test Plan:
- Ch1: LD_AR 0x1000, WR_CR 0000, LD_WCR 3, ENABLE 1, 4 steps -> acks with addr 0x1000, 0x1001, 0x1002; done[1]=1 and done_pls on the 3rd ack; 4th request gives no ack.
- Ch2: CR=0100 (decrement), AR=0x0001, WCR=5, 3 steps -> addr 0x0001, 0x0000, 0xFFFF; aco=1 on the 2nd ack only; RD_AC returns 0xFFFE.
- Ch0: CR=1001 (auto-reinit, mode 01), AR=0x20, WCR=2, 5 steps -> addr 0x20, 0x21, 0x20, 0x21, 0x20; done_pls on acks 2 and 4; done[0] stays 0.
- Ch3: CR=0010 (address compare), AR=0x40, WCR=0x42 -> done on the 2nd ack; RD_WC returns 2.
- Same cycle: LD_AR on ch1 plus cnt_en on ch1 -> no ack, AC=din. Same cycle LD_AR on ch0 plus step on ch1 -> both take effect.
- Assert rst while ch1 has 2 of WCR=4 steps done -> all outputs 0 immediately; after release RD_WC=0, done=0, and steps are refused (EN=0).

Source files
------------

// File: rtl/dma_addr_gen_mc.sv
// -----------------------------------------------------------------------------
// dma_addr_gen_mc
//
// Multi-channel DMA address generator. Each of NCH channels owns an address
// register (AR), a word-count register (WCR), an address counter (AC), a word
// counter (WC), a 4-bit control register (CR), an enable bit (EN) and a done
// flag. One instruction port programs and reads back channels. One step port
// requests a transfer step on a channel; an accepted step is acknowledged one
// cycle later together with the address that was issued.
//
// CR[1:0] terminal mode : 00 WC down to 0, 01 WC up to WCR,
//                         10 AC reaches WCR, 11 free-run
// CR[2]                 : 0 AC increments, 1 AC decrements
// CR[3]                 : auto-reinitialise on terminal count
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active high
//   instr_vld  execute instr on channel ch_sel this cycle
//   instr      instruction code (see instr_e)
//   ch_sel     channel targeted by instr
//   din        instruction data
//   dout       readback data (holds between reads)
//   dout_vld   one-cycle pulse after a read instruction
//   cnt_en     request one transfer step on cnt_ch
//   cnt_ch     channel to step
//   cnt_ack    one-cycle pulse: step accepted
//   addr       address issued by the accepted step (AC before the step)
//   aco        address counter wrapped on the accepted step
//   wco        word counter carry/borrow on the accepted step
//   done       per-channel terminal-count level
//   done_pls   pulse with cnt_ack when the step hit terminal count
//
// All outputs are registered; there is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module dma_addr_gen_mc #(
  parameter  int W   = 16,
  parameter  int NCH = 4,
  localparam int CHW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_vld,
  input  logic [2:0]     instr,
  input  logic [CHW-1:0] ch_sel,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout,
  output logic           dout_vld,
  input  logic           cnt_en,
  input  logic [CHW-1:0] cnt_ch,
  output logic           cnt_ack,
  output logic [W-1:0]   addr,
  output logic           aco,
  output logic           wco,
  output logic [NCH-1:0] done,
  output logic           done_pls
);

  typedef enum logic [2:0] {
    I_WR_CR  = 3'd0,
    I_RD_CR  = 3'd1,
    I_RD_WC  = 3'd2,
    I_RD_AC  = 3'd3,
    I_REINIT = 3'd4,
    I_LD_AR  = 3'd5,
    I_LD_WCR = 3'd6,
    I_ENABLE = 3'd7
  } instr_e;

  typedef enum logic [1:0] {
    M_WC_DOWN  = 2'b00,
    M_WC_UP    = 2'b01,
    M_ADDR_CMP = 2'b10,
    M_FREE_RUN = 2'b11
  } mode_e;

  // Per-channel state
  logic [W-1:0]   ar  [NCH];
  logic [W-1:0]   wcr [NCH];
  logic [W-1:0]   ac  [NCH];
  logic [W-1:0]   wc  [NCH];
  logic [3:0]     cr  [NCH];
  logic [NCH-1:0] en;

  // Step datapath for the channel selected by cnt_ch
  logic [W-1:0] ac_cur, wc_cur, wcr_cur, ar_cur;
  logic [W-1:0] ac_step, wc_step, wc_reload;
  logic [3:0]   cr_cur;
  mode_e        mode_cur;
  logic         step_ok, aco_n, wco_n, term;
  instr_e       op;

  assign op = instr_e'(instr);

  // NOTE: every signal gets a default at the top of the always_comb so no
  // path leaves it unassigned; that is what keeps this block latch-free.
  always_comb begin
    ac_cur    = ac[cnt_ch];
    wc_cur    = wc[cnt_ch];
    wcr_cur   = wcr[cnt_ch];
    ar_cur    = ar[cnt_ch];
    cr_cur    = cr[cnt_ch];
    mode_cur  = mode_e'(cr_cur[1:0]);
    ac_step   = ac_cur;
    wc_step   = wc_cur;
    aco_n     = 1'b0;
    wco_n     = 1'b0;
    term      = 1'b0;
    wc_reload = '0;

    // A same-cycle instruction on the stepping channel takes priority.
    step_ok = cnt_en && en[cnt_ch] && !done[cnt_ch] &&
              !(instr_vld && (ch_sel == cnt_ch));

    if (cr_cur[2]) begin
      ac_step = ac_cur - W'(1);
      aco_n   = (ac_cur == '0);
    end else begin
      ac_step = ac_cur + W'(1);
      aco_n   = &ac_cur;
    end

    if (mode_cur == M_WC_DOWN) begin
      wc_step   = wc_cur - W'(1);
      // Borrow flags both reaching zero and wrapping below it.
      wco_n     = (wc_cur == W'(1)) || (wc_cur == '0);
      wc_reload = wcr_cur;
    end else begin
      wc_step   = wc_cur + W'(1);
      wco_n     = &wc_cur;
    end

    // Terminal decision is taken on the post-step counter values.
    unique case (mode_cur)
      M_WC_DOWN:  term = (wc_step == '0);
      M_WC_UP:    term = (wc_step == wcr_cur);
      M_ADDR_CMP: term = (ac_step == wcr_cur);
      default:    term = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-channel arrays are small register files that must read
      // as zero straight out of reset, so they are reset explicitly rather
      // than left uninitialised like a RAM would be.
      for (int i = 0; i < NCH; i++) begin
        ar[i]  <= '0;
        wcr[i] <= '0;
        ac[i]  <= '0;
        wc[i]  <= '0;
        cr[i]  <= '0;
      end
      en       <= '0;
      done     <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      cnt_ack  <= 1'b0;
      addr     <= '0;
      aco      <= 1'b0;
      wco      <= 1'b0;
      done_pls <= 1'b0;
    end else begin
      cnt_ack  <= step_ok;
      aco      <= 1'b0;
      wco      <= 1'b0;
      done_pls <= 1'b0;
      dout_vld <= 1'b0;

      // Step update. When a step is accepted any instruction this cycle
      // targets a different channel, so the two never write the same entry.
      if (step_ok) begin
        addr     <= ac_cur;
        aco      <= aco_n;
        wco      <= wco_n;
        done_pls <= term;
        if (term && cr_cur[3]) begin
          ac[cnt_ch] <= ar_cur;
          wc[cnt_ch] <= wc_reload;
        end else begin
          ac[cnt_ch] <= ac_step;
          wc[cnt_ch] <= wc_step;
          if (term) done[cnt_ch] <= 1'b1;
        end
      end

      if (instr_vld) begin
        unique case (op)
          I_WR_CR: begin
            cr[ch_sel]   <= din[3:0];
            en[ch_sel]   <= 1'b0;
            done[ch_sel] <= 1'b0;
          end
          I_RD_CR: begin
            dout     <= {{(W-4){1'b0}}, cr[ch_sel]};
            dout_vld <= 1'b1;
          end
          I_RD_WC: begin
            dout     <= wc[ch_sel];
            dout_vld <= 1'b1;
          end
          I_RD_AC: begin
            dout     <= ac[ch_sel];
            dout_vld <= 1'b1;
          end
          I_REINIT: begin
            ac[ch_sel]   <= ar[ch_sel];
            wc[ch_sel]   <= (cr[ch_sel][1:0] == M_WC_DOWN) ? wcr[ch_sel] : '0;
            done[ch_sel] <= 1'b0;
          end
          I_LD_AR: begin
            ar[ch_sel] <= din;
            ac[ch_sel] <= din;
          end
          I_LD_WCR: begin
            wcr[ch_sel] <= din;
            wc[ch_sel]  <= (cr[ch_sel][1:0] == M_WC_DOWN) ? din : '0;
          end
          I_ENABLE: begin
            en[ch_sel]   <= din[0];
            done[ch_sel] <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_addr_gen_mc.sv
// -----------------------------------------------------------------------------
// tb_dma_addr_gen_mc
//
// Scoreboard bench for dma_addr_gen_mc. The driver applies one input vector
// per cycle and advances a behavioural channel model; expected acks and read
// data are queued. An independent monitor samples after every rising edge and
// compares whatever the DUT presents against the queue heads.
// -----------------------------------------------------------------------------
module tb_dma_addr_gen_mc;

  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int MOD = 1 << W;

  localparam logic [2:0] WR_CR = 3'd0, RD_CR = 3'd1, RD_WC = 3'd2, RD_AC = 3'd3,
                         REINIT = 3'd4, LD_AR = 3'd5, LD_WCR = 3'd6, ENABLE = 3'd7;

  logic           clk = 1'b0;
  logic           rst;
  logic           instr_vld;
  logic [2:0]     instr;
  logic [CHW-1:0] ch_sel;
  logic [W-1:0]   din;
  logic [W-1:0]   dout;
  logic           dout_vld;
  logic           cnt_en;
  logic [CHW-1:0] cnt_ch;
  logic           cnt_ack;
  logic [W-1:0]   addr;
  logic           aco;
  logic           wco;
  logic [NCH-1:0] done;
  logic           done_pls;

  dma_addr_gen_mc #(.W(W), .NCH(NCH)) dut (
    .clk(clk), .rst(rst),
    .instr_vld(instr_vld), .instr(instr), .ch_sel(ch_sel), .din(din),
    .dout(dout), .dout_vld(dout_vld),
    .cnt_en(cnt_en), .cnt_ch(cnt_ch), .cnt_ack(cnt_ack),
    .addr(addr), .aco(aco), .wco(wco), .done(done), .done_pls(done_pls)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int addr;
    bit aco;
    bit wco;
    bit dp;
  } ack_t;

  int   m_ar [NCH], m_wcr [NCH], m_ac [NCH], m_wc [NCH], m_cr [NCH];
  bit   m_en [NCH];
  bit   m_done [NCH];
  ack_t ack_q [$];
  int   rd_q  [$];

  function automatic logic [NCH-1:0] done_vec();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_done[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ar[i] = 0; m_wcr[i] = 0; m_ac[i] = 0; m_wc[i] = 0; m_cr[i] = 0;
      m_en[i] = 0; m_done[i] = 0;
    end
    ack_q.delete();
    rd_q.delete();
  endfunction

  function automatic void reload(int c);
    m_ac[c] = m_ar[c];
    m_wc[c] = ((m_cr[c] % 4) == 0) ? m_wcr[c] : 0;
  endfunction

  function automatic void model_cycle(bit iv, int op, int ich, int d, bit cen, int cch);
    int   mode, a0, a1, w0, w1;
    bit   term;
    ack_t r;
    if (cen && m_en[cch] && !m_done[cch] && !(iv && ich == cch)) begin
      mode = m_cr[cch] % 4;
      a0 = m_ac[cch];
      w0 = m_wc[cch];
      if ((m_cr[cch] / 4) % 2 == 1) begin
        a1 = (a0 + MOD - 1) % MOD; r.aco = (a0 == 0);
      end else begin
        a1 = (a0 + 1) % MOD;       r.aco = (a1 == 0);
      end
      if (mode == 0) begin
        w1 = (w0 + MOD - 1) % MOD; r.wco = (w1 == 0) || (w0 == 0);
      end else begin
        w1 = (w0 + 1) % MOD;       r.wco = (w1 == 0);
      end
      case (mode)
        0:       term = (w1 == 0);
        1:       term = (w1 == m_wcr[cch]);
        2:       term = (a1 == m_wcr[cch]);
        default: term = 0;
      endcase
      r.addr = a0;
      r.dp   = term;
      ack_q.push_back(r);
      if (term && m_cr[cch] >= 8) reload(cch);
      else begin
        m_ac[cch] = a1;
        m_wc[cch] = w1;
        if (term) m_done[cch] = 1;
      end
    end
    if (iv) begin
      case (op)
        0: begin m_cr[ich] = d % 16; m_en[ich] = 0; m_done[ich] = 0; end
        1: rd_q.push_back(m_cr[ich]);
        2: rd_q.push_back(m_wc[ich]);
        3: rd_q.push_back(m_ac[ich]);
        4: begin reload(ich); m_done[ich] = 0; end
        5: begin m_ar[ich] = d; m_ac[ich] = d; end
        6: begin m_wcr[ich] = d; m_wc[ich] = ((m_cr[ich] % 4) == 0) ? d : 0; end
        default: begin m_en[ich] = d[0]; m_done[ich] = 0; end
      endcase
    end
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(bit iv, logic [2:0] op, int ich, int d, bit cen, int cch);
    @(negedge clk);
    instr_vld = iv;
    instr     = op;
    ch_sel    = CHW'(ich);
    din       = W'(d);
    cnt_en    = cen;
    cnt_ch    = CHW'(cch);
    model_cycle(iv, int'(op), ich, d, cen, cch);
  endtask

  task automatic ins(logic [2:0] op, int ch, int d);
    cycle(1'b1, op, ch, d, 1'b0, 0);
  endtask

  task automatic step(int ch, int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 0, 0, 1'b1, ch);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 0, 0, 1'b0, 0);
  endtask

  task automatic setup(int ch, int crv, int arv, int wcrv);
    ins(WR_CR, ch, crv);
    ins(LD_AR, ch, arv);
    ins(LD_WCR, ch, wcrv);
    ins(ENABLE, ch, 1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    ack_t e;
    int   ed;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("done_level", 32'(done), 32'(done_vec()));
        check("cnt_ack", 32'(cnt_ack), 32'(ack_q.size() != 0));
        if (cnt_ack && ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("addr", 32'(addr), 32'(e.addr));
          check("aco", 32'(aco), 32'(e.aco));
          check("wco", 32'(wco), 32'(e.wco));
          check("done_pls", 32'(done_pls), 32'(e.dp));
        end
        check("dout_vld", 32'(dout_vld), 32'(rd_q.size() != 0));
        if (dout_vld && rd_q.size() != 0) begin
          ed = rd_q.pop_front();
          check("dout", 32'(dout), 32'(ed));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int op, ch, d;
    rst = 1'b1;
    instr_vld = 0; instr = 0; ch_sel = 0; din = 0; cnt_en = 0; cnt_ch = 0;
    model_reset();
    #1;
    check("rst_dout", 32'(dout), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ack", 32'(cnt_ack), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Ch1: count down 3, then done blocks the 4th request
    setup(1, 4'b0000, 'h1000, 3);
    step(1, 4);
    idle(1);
    check("ch1_done", 32'(done[1]), 1);

    // Ch2: decrementing address crossing zero
    setup(2, 4'b0100, 'h0001, 5);
    step(2, 3);
    ins(RD_AC, 2, 0);
    idle(1);

    // Ch0: auto-reinit in count-up mode
    setup(0, 4'b1001, 'h20, 2);
    step(0, 5);
    idle(1);
    check("ch0_done_low", 32'(done[0]), 0);

    // Ch3: address compare
    setup(3, 4'b0010, 'h40, 'h42);
    step(3, 3);
    ins(RD_WC, 3, 0);
    ins(RD_CR, 3, 0);
    idle(1);

    // Same-cycle collisions
    ins(ENABLE, 1, 1);
    cycle(1'b1, LD_AR, 1, 'h3000, 1'b1, 1);   // step dropped
    ins(RD_AC, 1, 0);
    cycle(1'b1, LD_AR, 0, 'h5000, 1'b1, 1);   // both execute
    ins(RD_AC, 0, 0);
    ins(RD_AC, 1, 0);
    ins(RD_WC, 1, 0);
    idle(1);

    // Reset in the middle of a run, with a step in flight
    setup(1, 4'b0000, 'h0100, 4);
    step(1, 2);
    cycle(1'b0, 3'd0, 0, 0, 1'b1, 1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_dout", 32'(dout), 0);
    check("mid_rst_dout_vld", 32'(dout_vld), 0);
    check("mid_rst_cnt_ack", 32'(cnt_ack), 0);
    check("mid_rst_addr", 32'(addr), 0);
    check("mid_rst_aco", 32'(aco), 0);
    check("mid_rst_wco", 32'(wco), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_done_pls", 32'(done_pls), 0);
    idle(1);
    rst = 1'b0;
    ins(RD_WC, 1, 0);
    step(1, 2);
    idle(1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 7);
      ch = $urandom_range(0, NCH - 1);
      case (op)
        0:       d = $urandom_range(0, 15);
        5:       d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MOD - 1)
                                                 : (($urandom_range(0, 1) == 1) ? $urandom_range(0, 4)
                                                                                : MOD - 1 - $urandom_range(0, 4));
        6:       d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MOD - 1) : $urandom_range(0, 6);
        7:       d = ($urandom_range(0, 3) != 0) ? 1 : 0;
        default: d = $urandom_range(0, MOD - 1);
      endcase
      cycle($urandom_range(0, 9) < 3, 3'(op), ch, d,
            $urandom_range(0, 9) < 7, $urandom_range(0, NCH - 1));
    end
    idle(3);

    check("ack_q_drained", 32'(ack_q.size()), 0);
    check("rd_q_drained", 32'(rd_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
